// File: rtl/axil_wr_arbiter.sv
// N-to-1 AXI-Lite write-channel arbiter: round-robin grant held until B, local DECERR for undecodable writes.
// Build option: define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module axil_wr_arbiter #(
    parameter  int N          = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB       = DATA_WIDTH / 8,
    localparam int IDW        = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            s_awvalid,
    output logic [N-1:0]            s_awready,
    input  logic [N*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [N-1:0]            s_wvalid,
    output logic [N-1:0]            s_wready,
    input  logic [N*DATA_WIDTH-1:0] s_wdata,
    input  logic [N*STRB-1:0]       s_wstrb,
    output logic [N-1:0]            s_bvalid,
    input  logic [N-1:0]            s_bready,
    output logic [N*2-1:0]          s_bresp,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [STRB-1:0]         m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic [ADDR_WIDTH-1:0]   dec_addr,
    input  logic                    dec_err,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy
);

    typedef enum logic [2:0] {S_IDLE, S_FWD, S_RESP, S_ERR_AW_W, S_ERR_B} state_t;

    state_t                r_state, w_state_nxt;
    logic [IDW-1:0]        r_grant, w_cand, w_ptr;
    logic                  r_aw_done, r_w_done;
    logic                  w_any, w_aw_hs, w_w_hs;
    logic                  w_g_awvalid, w_g_wvalid, w_g_bready;
    logic                  w_g_awready, w_g_wready, w_g_bvalid;
    logic [1:0]            w_g_bresp;
    logic [ADDR_WIDTH-1:0] w_awaddr [N];
    logic [DATA_WIDTH-1:0] w_wdata  [N];
    logic [STRB-1:0]       w_wstrb  [N];

    // Per-master fan-out: only the granted lane sees the shared channel signals.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign w_awaddr[gi]          = s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[gi]           = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_wstrb[gi]           = s_wstrb[gi*STRB +: STRB];
        assign s_awready[gi]         = w_g_awready && (r_grant == IDW'(gi));
        assign s_wready[gi]          = w_g_wready  && (r_grant == IDW'(gi));
        assign s_bvalid[gi]          = w_g_bvalid  && (r_grant == IDW'(gi));
        assign s_bresp[gi*2 +: 2]    = (r_grant == IDW'(gi)) ? w_g_bresp : 2'b00;
    end

`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDW-1:0] r_rr_ptr;
    assign w_ptr = r_rr_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (r_state == S_IDLE && w_any)
            r_rr_ptr <= (w_cand == IDW'(N-1)) ? '0 : w_cand + IDW'(1);
    end
`endif

    always_comb begin
        int unsigned idx;
        idx    = 0;
        w_any  = 1'b0;
        w_cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(w_ptr) + k) % N;
            if (!w_any && s_awvalid[IDW'(idx)]) begin
                w_any  = 1'b1;
                w_cand = IDW'(idx);
            end
        end
    end

    assign w_g_awvalid = s_awvalid[r_grant];
    assign w_g_wvalid  = s_wvalid[r_grant];
    assign w_g_bready  = s_bready[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        w_aw_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_g_awready = 1'b0;
        w_g_wready  = 1'b0;
        w_g_bvalid  = 1'b0;
        w_g_bresp   = 2'b00;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any)
                    w_state_nxt = dec_err ? S_ERR_AW_W : S_FWD;
            end
            S_FWD: begin
                m_awvalid   = w_g_awvalid && !r_aw_done;
                w_g_awready = m_awready && !r_aw_done;
                m_wvalid    = w_g_wvalid && !r_w_done;
                w_g_wready  = m_wready && !r_w_done;
                w_aw_hs     = w_g_awvalid && m_awready && !r_aw_done;
                w_w_hs      = w_g_wvalid && m_wready && !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_g_bvalid = m_bvalid;
                w_g_bresp  = m_bresp;
                m_bready   = w_g_bready;
                if (m_bvalid && w_g_bready)
                    w_state_nxt = S_IDLE;
            end
            S_ERR_AW_W: begin
                w_g_awready = !r_aw_done;
                w_g_wready  = !r_w_done;
                w_aw_hs     = w_g_awvalid && !r_aw_done;
                w_w_hs      = w_g_wvalid && !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_state_nxt = S_ERR_B;
            end
            S_ERR_B: begin
                w_g_bvalid = 1'b1;
                w_g_bresp  = 2'b11;
                if (w_g_bready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_any)
                    r_grant <= w_cand;
            end else begin
                r_aw_done <= r_aw_done || w_aw_hs;
                r_w_done  <= r_w_done || w_w_hs;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant;
    assign m_awaddr = busy ? w_awaddr[r_grant] : '0;
    assign m_wdata  = busy ? w_wdata[r_grant]  : '0;
    assign m_wstrb  = busy ? w_wstrb[r_grant]  : '0;
    assign dec_addr = busy ? w_awaddr[r_grant] : w_awaddr[w_cand];

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Bench for axil_wr_arbiter: reset/round-robin sequence, table of single writes, reset mid-response.
module tb_axil_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   s_awvalid = '0, s_awready, s_wvalid = '0, s_wready;
    logic [3:0]   s_bvalid, s_bready = '0;
    logic [127:0] s_awaddr, s_wdata;
    logic [15:0]  s_wstrb;
    logic [7:0]   s_bresp;
    logic         m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0;
    logic [31:0]  m_awaddr, m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_bvalid = 1'b0, m_bready;
    logic [1:0]   m_bresp = 2'b00;
    logic [31:0]  dec_addr;
    logic         dec_err;
    logic [1:0]   grant_id;
    logic         busy;

    logic [31:0]  tb_awaddr [4] = '{default: '0};
    logic [31:0]  tb_wdata  [4] = '{default: '0};
    logic [3:0]   tb_wstrb  [4] = '{default: '0};

    assign s_awaddr = {tb_awaddr[3], tb_awaddr[2], tb_awaddr[1], tb_awaddr[0]};
    assign s_wdata  = {tb_wdata[3], tb_wdata[2], tb_wdata[1], tb_wdata[0]};
    assign s_wstrb  = {tb_wstrb[3], tb_wstrb[2], tb_wstrb[1], tb_wstrb[0]};
    // Decoder model: the 0x5000 page is unmapped.
    assign dec_err  = (dec_addr[31:12] == 20'h00005);

    always #5 clk = ~clk;

    axil_wr_arbiter #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .dec_addr(dec_addr), .dec_err(dec_err), .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        int unsigned id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        derr;
        logic [1:0]  mresp;
        int unsigned dawd;
        int unsigned bd;
        int unsigned exp_n;
    } vec_t;

    typedef struct {
        int unsigned gid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic        fwd;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard side: collect downstream beats, compare on each upstream B handshake.
    initial begin
        int          cap_aw, cap_w;
        logic [31:0] cap_addr, cap_data;
        logic [3:0]  cap_strb;
        exp_t        e;
        cap_aw = 0; cap_w = 0; cap_addr = '0; cap_data = '0; cap_strb = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                cap_aw = 0;
                cap_w  = 0;
            end else begin
                if (m_awvalid && m_awready) begin cap_aw++; cap_addr = m_awaddr; end
                if (m_wvalid && m_wready) begin cap_w++; cap_data = m_wdata; cap_strb = m_wstrb; end
                if (|(s_bvalid & s_bready)) begin
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_b", 64'(s_bvalid), 64'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_bvalid", 64'(s_bvalid), 64'(4'(1) << e.gid));
                        chk("sb_grant", 64'(grant_id), 64'(e.gid));
                        chk("sb_bresp", 64'(s_bresp), 64'(8'(e.resp) << (2 * e.gid)));
                        chk("sb_aw_beats", 64'(cap_aw), e.fwd ? 64'd1 : 64'd0);
                        chk("sb_w_beats", 64'(cap_w), e.fwd ? 64'd1 : 64'd0);
                        if (e.fwd) begin
                            chk("sb_awaddr", 64'(cap_addr), 64'(e.addr));
                            chk("sb_wdata", 64'(cap_data), 64'(e.data));
                            chk("sb_wstrb", 64'(cap_strb), 64'(e.strb));
                        end
                        cap_aw = 0;
                        cap_w  = 0;
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int unsigned n, aw_wait, b_wait, aw_cnt, w_cnt, hold_bad;
        logic        awp, wp, bp, ah, wh, bh;
        logic [1:0]  mid;
        logic [1:0]  eresp;
        mid   = v.id[1:0];
        eresp = v.derr ? 2'b11 : v.mresp;
        @(negedge clk);
        tb_awaddr[mid] = v.addr;
        tb_wdata[mid]  = v.data;
        tb_wstrb[mid]  = v.strb;
        s_awvalid[mid] = 1'b1;
        s_wvalid[mid]  = 1'b1;
        m_wready       = 1'b1;
        m_bvalid       = 1'b1;
        m_bresp        = v.mresp;
        sbq.push_back('{v.id, v.addr, v.data, v.strb, eresp, !v.derr});
        n = 0; aw_wait = 0; b_wait = 0; aw_cnt = 0; w_cnt = 0; hold_bad = 0;
        awp = 1'b1; wp = 1'b1; bp = 1'b1;
        while ((awp || wp || bp) && n < 30) begin
            m_awready      = (aw_wait >= v.dawd);
            s_bready[mid]  = (b_wait >= v.bd);
            #1;
            ah = awp && s_awready[mid];
            wh = wp && s_wready[mid];
            bh = bp && s_bvalid[mid] && s_bready[mid];
            if (m_awvalid && m_awready) aw_cnt++;
            if (m_wvalid && m_wready) w_cnt++;
            if (m_awvalid && !m_awready) aw_wait++;
            if (s_bvalid[mid] && !s_bready[mid]) begin
                b_wait++;
                if (2'(s_bresp >> (2 * v.id)) != eresp) hold_bad++;
            end
            if (n == 1) begin
                chk("vec_awaddr_c1", 64'(m_awaddr), 64'(v.addr));
                chk("vec_awvalid_c1", 64'(m_awvalid), 64'(!v.derr));
            end
            @(negedge clk);
            n++;
            if (ah) begin awp = 1'b0; s_awvalid[mid] = 1'b0; end
            if (wh) begin wp = 1'b0; s_wvalid[mid] = 1'b0; end
            if (bh) bp = 1'b0;
        end
        s_bready = '0;
        m_bvalid = 1'b0;
        #1;
        chk("vec_cycles", 64'(n), 64'(v.exp_n));
        chk("vec_busy_end", 64'(busy), 64'h0);
        chk("vec_m_aw_beats", 64'(aw_cnt), v.derr ? 64'd0 : 64'd1);
        chk("vec_m_w_beats", 64'(w_cnt), v.derr ? 64'd0 : 64'd1);
        if (v.bd > 0) begin
            chk("vec_b_hold_cycles", 64'(b_wait), 64'(v.bd));
            chk("vec_b_hold_resp", 64'(hold_bad), 64'h0);
        end
    endtask

    initial begin
        vec_t        tbl[6];
`ifdef AXIL_ARB_FIXED_PRIO_EN
        int unsigned ord[5] = '{0, 0, 0, 0, 0};
`else
        int unsigned ord[5] = '{0, 1, 2, 3, 0};
`endif
        int unsigned k, n;
        logic        prev;

        //            id  addr           data           strb  derr  mresp dawd bd exp_n
        tbl[0] = '{2, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'b00, 0, 0, 3};
        tbl[1] = '{0, 32'h0000_2000, 32'h1234_5678, 4'h3, 1'b0, 2'b10, 0, 0, 3};
        tbl[2] = '{1, 32'h0000_5000, 32'hCAFE_F00D, 4'hF, 1'b1, 2'b00, 0, 3, 6};
        tbl[3] = '{3, 32'h0000_3008, 32'hA5A5_A5A5, 4'hC, 1'b0, 2'b00, 2, 0, 5};
        tbl[4] = '{1, 32'h0000_5FFC, 32'h0000_0001, 4'h1, 1'b1, 2'b00, 0, 0, 3};
        tbl[5] = '{3, 32'h0000_4000, 32'h55AA_55AA, 4'h1, 1'b0, 2'b01, 0, 1, 4};

        // Reset with every master requesting; all outputs must stay quiet.
        tb_awaddr[0] = 32'h1000; tb_awaddr[1] = 32'h1010; tb_awaddr[2] = 32'h1020; tb_awaddr[3] = 32'h1030;
        tb_wdata[0] = 32'h1111_1111; tb_wdata[1] = 32'h2222_2222;
        tb_wdata[2] = 32'h3333_3333; tb_wdata[3] = 32'h4444_4444;
        tb_wstrb[0] = 4'hF; tb_wstrb[1] = 4'hF; tb_wstrb[2] = 4'hF; tb_wstrb[3] = 4'hF;
        s_awvalid = 4'hF; s_wvalid = 4'hF; s_bready = 4'hF;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_grant", 64'(grant_id), 64'h0);
        chk("rst_s_awready", 64'(s_awready), 64'h0);
        chk("rst_s_wready", 64'(s_wready), 64'h0);
        chk("rst_s_bvalid", 64'(s_bvalid), 64'h0);
        chk("rst_s_bresp", 64'(s_bresp), 64'h0);
        chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_bready}), 64'h0);
        chk("rst_m_awaddr", 64'(m_awaddr), 64'h0);
        chk("rst_m_wdata", 64'(m_wdata), 64'h0);

        for (int i = 0; i < 5; i++)
            sbq.push_back('{ord[i], 32'(32'h1000 + ord[i] * 16), 32'(32'h1111_1111 * (ord[i] + 1)),
                            4'hF, 2'b00, 1'b1});
        rst  = 1'b0;
        k    = 0;
        n    = 0;
        prev = 1'b0;
        while (k < 5 && n < 40) begin
            @(negedge clk);
            n++;
            #1;
            if (busy && !prev) begin
                chk("rr_grant", 64'(grant_id), 64'(ord[k]));
                chk("rr_m_awvalid", 64'(m_awvalid), 64'h1);
                k++;
            end
            prev = busy;
        end
        chk("rr_grants_seen", 64'(k), 64'd5);
        @(negedge clk);
        s_awvalid = '0;
        s_wvalid  = '0;
        @(negedge clk);
        s_bready  = '0;
        m_bvalid  = 1'b0;
        #1;
        chk("rr_idle_after", 64'(busy), 64'h0);

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i]);

        // Reset while the downstream response is pending.
        @(negedge clk);
        tb_awaddr[2] = 32'h0000_1100;
        s_awvalid[2] = 1'b1;
        s_wvalid[2]  = 1'b1;
        m_awready    = 1'b1;
        m_wready     = 1'b1;
        m_bvalid     = 1'b0;
        s_bready     = '0;
        @(negedge clk);
        @(negedge clk);
        s_awvalid = '0;
        s_wvalid  = '0;
        m_bvalid  = 1'b1;
        #1;
        chk("mid_resp_bvalid", 64'(s_bvalid), 64'h4);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_bvalid", 64'(s_bvalid), 64'h0);
        chk("mid_rst_grant", 64'(grant_id), 64'h0);
        chk("mid_rst_m_bready", 64'(m_bready), 64'h0);
        rst       = 1'b0;
        m_bvalid  = 1'b0;
        tb_awaddr[1] = 32'h0000_1200;
        tb_awaddr[3] = 32'h0000_1300;
        s_awvalid = 4'b1010;
        s_wvalid  = 4'b1010;
        @(negedge clk);
        #1;
        chk("post_rst_ptr_grant", 64'(grant_id), 64'h1);
        chk("post_rst_busy", 64'(busy), 64'h1);
        rst       = 1'b1;
        s_awvalid = '0;
        s_wvalid  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("sb_queue_empty", 64'(sbq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_wr_arbiter.md
# axil_wr_arbiter

N-to-1 AXI-Lite write-channel arbiter that shares one downstream write port (crossbar slave side) among N upstream masters. It grants one write transaction at a time using round-robin arbitration. The grant holds until the B handshake completes. The arbiter drives the shared address decoder with the candidate address and answers undecodable writes locally with DECERR, without forwarding them downstream.

## Interface
- N, 4, number of upstream masters (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; STRB = DATA_WIDTH/8
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- s_awvalid / s_awready  in / out  N  per-master AW handshake
- s_awaddr  in  N×ADDR_WIDTH  per-master AW address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_wvalid / s_wready  in / out  N  per-master W handshake
- s_wdata / s_wstrb  in  N×DATA_WIDTH / N×STRB  per-master write data/strobe
- s_bvalid / s_bready  out / in  N  per-master B handshake
- s_bresp  out  N×2  per-master response
- m_awvalid / m_awready  out / in  1  downstream AW
- m_awaddr  out  ADDR_WIDTH  downstream AW address
- m_wvalid / m_wready, m_wdata, m_wstrb  out/in, DATA_WIDTH, STRB  downstream W
- m_bvalid / m_bready / m_bresp  in / out / in  1,1,2  downstream B
- dec_addr  out  ADDR_WIDTH  address presented to the decoder
- dec_err  in  1  decoder error (combinational from dec_addr)
- grant_id  out  $clog2(N)  index of the granted master, valid when busy
- busy  out  1  transaction in progress (state ≠ IDLE)

## Operation
- States: IDLE, FWD, RESP, ERR_AW_W, ERR_B.
- IDLE: the candidate is the first i with s_awvalid[i], searched from rr_ptr upward with wrap. dec_addr = s_awaddr[candidate]. If any request exists, the arbiter registers grant_id = candidate and err_q = dec_err. It sets rr_ptr = candidate+1 mod N. Next state is ERR_AW_W if dec_err, else FWD. Nothing is accepted in IDLE, so all s_*ready = 0.
- FWD: route the granted master only.
  - m_awvalid = s_awvalid[g] & !aw_done.
  - s_awready[g] = m_awready & !aw_done.
  - W channel identical, using w_done.
  - aw_done and w_done set on their handshakes and clear on entry to FWD. AW and W complete in either order or in the same cycle.
  - When both are done (including same-cycle completion), go to RESP.
- RESP: s_bvalid[g] = m_bvalid, s_bresp[g] = m_bresp, m_bready = s_bready[g]. On handshake, go to IDLE.
- ERR_AW_W: no downstream valids. s_awready[g] = !aw_done and s_wready[g] = !w_done; the arbiter sinks AW and W locally. When both are done, go to ERR_B.
- ERR_B: s_bvalid[g] = 1 and s_bresp[g] = 2'b11 until s_bready[g]; then go to IDLE.
- Non-granted masters: ready = 0, bvalid = 0, bresp = 0.
- m_awaddr, m_wdata and m_wstrb are muxed from g while busy; they are 0 in IDLE.
- N masters waiting continuously are served in order i, i+1, …, wrap. Each waits at most N−1 transactions.
- A master dropping awvalid in IDLE before grant is legal and is simply not selected.

## Timing
- Reset, checked on the clock edge: state = IDLE, rr_ptr = 0, grant_id = 0, busy = 0, aw_done = w_done = 0. All valid/ready outputs are 0 and all resp outputs are 0.
- Grant latency: s_awvalid high in IDLE at cycle 0 gives busy = 1 and m_awvalid = 1 at cycle 1.
- Minimum transaction (zero-wait downstream):
  - AW and W accepted at cycle 1.
  - B handshake at cycle 2.
  - IDLE at cycle 3.
  - Next grant visible at cycle 4.
- Every downstream valid/ready is a direct combinational pass-through while in FWD/RESP. There are no bubbles beyond the state transitions.
- rst asserted mid-transaction aborts everything immediately. Upstream and downstream handshakes in flight are dropped; the environment must reset together.

## Configuration
- AXIL_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins; rr_ptr is removed (treated as 0).
  - Undefined: round-robin as above.

## Test plan
- Reset: hold rst 2 cycles with s_awvalid = 4'b1111 → all outputs 0, busy = 0. The first grant after release goes to master 0.
- Single write: master 2 issues AW 0x1004, W 0xDEADBEEF/4'hF, downstream zero-wait → m_awaddr = 0x1004 at cycle 1, s_bvalid[2] at cycle 2 with bresp = 0, busy low at cycle 3.
- Round-robin: all 4 masters request continuously → grant order 0,1,2,3,0. With AXIL_ARB_FIXED_PRIO_EN, the order is 0,0,0 while master 0 keeps requesting.
- Decode error: master 1 writes 0x0000_5000 with dec_err = 1 → no m_awvalid/m_wvalid ever. AW and W are accepted locally, then s_bresp[1] = 2'b11 with bvalid held until bready.
- W before AW: master 3 gives W at cycle 1 and AW at cycle 4, with downstream awready delayed 2 cycles → single m_wvalid handshake, RESP entered only after the AW handshake, B forwarded correctly.
- Reset mid-RESP: rst while m_bvalid is pending → next cycle state IDLE, s_bvalid = 0, rr_ptr = 0.
